mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, data word width; only 32 is supported.
REQ-002 Parameter: ADDR_WIDTH, 16, word-address width of the memory port.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 req_valid  in  1  CPU request valid.
REQ-006 req_ready  out  1  controller can accept a request (high only in IDLE).
REQ-007 req_we  in  1  0 = load, 1 = store.
REQ-008 req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-009 req_signed  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 req_addr  in  ADDR_WIDTH+2  byte address; word address = req_addr[ADDR_WIDTH+1:2].
REQ-011 req_wdata  in  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  out  1  one-cycle response pulse; no back-pressure.
REQ-013 rsp_rdata  out  WIDTH  load result, extended; 0 for stores and errors.
REQ-014 rsp_err  out  1  misaligned access flag, valid with rsp_valid.
REQ-015 mem_mode  out  1  memory port mode: 0 = read, 1 = write.
REQ-016 mem_addr  out  ADDR_WIDTH  memory word address.
REQ-017 mem_wdata  out  WIDTH  memory write data.
REQ-018 mem_rdata  in  WIDTH  memory read data, valid one cycle after a read is presented.

Function
REQ-019 The request is accepted on a posedge with req_valid && req_ready; the address, size, signedness, write enable and write data are latched at that edge.
REQ-020 States: IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP.
REQ-021 IDLE transitions on accept:
- misaligned -> RESP with error;
- load -> RD;
- word store -> WR;
- byte/half store -> RMW_RD.
REQ-022 Other transitions:
- RD -> RD_WAIT -> RESP;
- RMW_RD -> RMW_WAIT -> WR -> RESP;
- RESP -> IDLE.
REQ-023 Misaligned means: half with addr[0]=1, or word with addr[1:0]!=00.
REQ-024 In RD and RMW_RD, mem_mode=0 and mem_addr=latched word address.
REQ-025 In RD_WAIT and RMW_WAIT, mem_rdata is captured.
REQ-026 In WR, mem_mode=1 for exactly one cycle; mem_mode=0 in every other state.
REQ-027 Byte lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1] (0 = bits [15:0]).
REQ-028 Load extraction: select the lane, then sign-extend or zero-extend to 32 bits per req_signed; word loads pass through unchanged.
REQ-029 RMW merge: replace only the addressed lane of the captured word with req_wdata's low byte or half; all other bits are preserved.
REQ-030 Latency, with the accept cycle as C0, rsp_valid is high in:
- C3 for a load;
- C2 for a word store;
- C4 for a byte/half store;
- C1 for an error.
REQ-031 A misaligned request performs no memory access; rsp_err=1 and rsp_rdata=0.
REQ-032 req_ready=0 in every state except IDLE; requests presented then are ignored, not queued.
REQ-033 rsp_valid, rsp_err and rsp_rdata are registered and held at 0 outside RESP.

Reset
REQ-034 When reset=0 at a posedge, the block enters IDLE and drives rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_mode=0, mem_addr=0 and mem_wdata=0.
REQ-035 Reset takes priority over any transfer; an in-flight operation is abandoned, no response is produced, and no write is issued in the cycle after the reset edge.

Configuration
REQ-036 Macro MEM_CTRL_MISALIGN_TRAP_EN, when defined: misaligned requests behave per REQ-021, REQ-023 and REQ-031.
REQ-037 Without the macro:
- the low address bits are masked to size alignment (half: addr[0]=0; word: addr[1:0]=00);
- the access proceeds normally;
- rsp_err is tied to 0.

Verification
REQ-038 The bench SHALL cover these scenarios:
- Word load, memory word 3 = 0x8899AABB, req_addr=0x00C -> rsp_rdata=0x8899AABB in C3, rsp_err=0.
- Signed byte load from the word above at addr 0x00F, req_signed=1 -> 0xFFFFFF88; same load with req_signed=0 -> 0x00000088.
- Half store 0x1234 to addr 0x00E, word 3 = 0x8899AABB -> single mem_mode=1 cycle in C3 with mem_wdata=0x1234AABB; rsp_valid in C4.
- Word load at addr 0x002 with the macro defined -> rsp_valid in C1, rsp_err=1, mem_mode never 1; without the macro -> word 0 returned, rsp_err=0.
- reset=0 asserted in the WR cycle of a byte store -> mem_mode=0 from the next cycle, no rsp_valid; a subsequent word load completes normally.
- req_valid held high during a busy load -> second request accepted only in the cycle after RESP; req_ready=0 throughout.

Source files
------------

// File: rtl/mem_ctrl.sv
// Single-port memory controller: byte/half/word loads and stores, read-modify-write for sub-word stores.
// Optional misaligned-access trap enabled by defining MEM_CTRL_MISALIGN_TRAP_EN.
module mem_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP} state_t;

    state_t                state, next_state;
    logic                  lat_signed;
    logic [1:0]            lat_size;
    logic [1:0]            lat_lane;
    logic [WIDTH-1:0]      lat_wdata;

    logic                  accept_c;
    logic                  misaligned_c;
    logic [1:0]            req_lane_c;
    logic                  rsp_valid_d, rsp_err_d, mem_mode_d;
    logic [WIDTH-1:0]      rsp_rdata_d, mem_wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    assign misaligned_c = req_size[1] ? (req_addr[1:0] != 2'b00) : (req_size[0] & req_addr[0]);
`else
    assign misaligned_c = 1'b0;
`endif

    // Lane is forced to size alignment; aligned requests are unaffected.
    assign req_lane_c = req_size[1] ? 2'b00 : (req_size[0] ? {req_addr[1], 1'b0} : req_addr[1:0]);

    function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [WIDTH-1:0] sh;
        logic [HALF_W-1:0] h;
        logic [BYTE_W-1:0] b;
        sh = word >> {lane, 3'b000};
        h  = sh[HALF_W-1:0];
        b  = sh[BYTE_W-1:0];
        if (size[1])
            extract = word;
        else if (size[0])
            extract = {{(WIDTH-HALF_W){sgn & h[HALF_W-1]}}, h};
        else
            extract = {{(WIDTH-BYTE_W){sgn & b[BYTE_W-1]}}, b};
    endfunction

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] data,
                                               input logic [1:0] lane, input logic [1:0] size);
        logic [WIDTH-1:0] mask;
        mask  = size[0] ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF);
        merge = (word & ~(mask << {lane, 3'b000})) | ((data & mask) << {lane, 3'b000});
    endfunction

    // Next state and next registered outputs.
    always_comb begin
        next_state  = state;
        accept_c    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_mode_d  = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c   = 1'b1;
                    mem_addr_d = req_addr[ADDR_WIDTH+1:2];
                    if (misaligned_c) begin
                        next_state  = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        next_state = RD;
                    end else if (req_size[1]) begin
                        next_state  = WR;
                        mem_mode_d  = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            RD:      next_state = RD_WAIT;
            RD_WAIT: begin
                next_state  = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extract(mem_rdata, lat_lane, lat_size, lat_signed);
            end
            RMW_RD:  next_state = RMW_WAIT;
            RMW_WAIT: begin
                next_state  = WR;
                mem_mode_d  = 1'b1;
                mem_wdata_d = merge(mem_rdata, lat_wdata, lat_lane, lat_size);
            end
            WR: begin
                next_state  = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_mode   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_signed <= 1'b0;
            lat_size   <= 2'b00;
            lat_lane   <= 2'b00;
            lat_wdata  <= '0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == IDLE);
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_mode  <= mem_mode_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (accept_c) begin
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_lane   <= req_lane_c;
                lat_wdata  <= req_wdata;
            end
        end
    end

endmodule
